aib_axi_wr_traffic_gen: RTL and testbench
=========================================

AIB_AXI_WR_TRAFFIC_GEN -- requirements
Module: aib_axi_wr_traffic_gen

Interface
REQ-001 Parameter IDWIDTH, default 4, AXI ID width.
REQ-002 Parameter ADDRWIDTH, default 32, AXI address width.
REQ-003 Parameter TIMEOUT_CYC, default 1024, B-channel watchdog limit in cycles (used only with the configuration macro).
REQ-004 clk_wr  input  1  single clock; all logic rising-edge.
REQ-005 rst_wr  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to issue one write burst.
REQ-007 cfg_addr  input  ADDRWIDTH  burst start address.
REQ-008 cfg_len  input  8  AXI length (beats minus 1).
REQ-009 cfg_id  input  IDWIDTH  transaction ID.
REQ-010 cfg_seed  input  32  data pattern seed.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 done  output  1  one-cycle pulse at burst completion.
REQ-013 err  output  1  sticky; set on BRESP != OKAY, BID mismatch or timeout; cleared by the next accepted start.
REQ-014 timeout  output  1  sticky watchdog flag; cleared by the next accepted start.
REQ-015 m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  output; m_axi_awready  input  standard AXI4 AW channel.
REQ-016 m_axi_wid (IDWIDTH)/wdata (128)/wstrb (16)/wlast/wvalid  output; m_axi_wready  input.
REQ-017 m_axi_bid (IDWIDTH)/bresp (2)/bvalid  input; m_axi_bready  output.

Function
REQ-018 FSM states: IDLE, AW, W, B, DONE; encoding is implementer's choice.
REQ-019 IDLE: start=1 captures cfg_* into registers, clears err/timeout and the beat counter, and moves to AW the next cycle.
REQ-020 start is ignored in every state other than IDLE.
REQ-021 AW: awvalid=1 with awaddr/awlen/awid from the captured registers, awsize=3'b100 and awburst=2'b01; hold until awvalid&awready, then move to W.
REQ-022 AW payload stays stable while awvalid=1 and awready=0.
REQ-023 W: wvalid=1, wstrb=16'hFFFF, wid=captured id, wdata={4{seed+beat}} (32-bit add, wraps modulo 2^32).
REQ-024 Beat counter is 8 bits and increments only on wvalid&wready.
REQ-025 wlast=1 exactly when beat counter equals captured len; wvalid&wready&wlast moves to B.
REQ-026 W payload stays stable while wvalid=1 and wready=0; no AW/W overlap (W starts only after the AW handshake).
REQ-027 len=0: a single beat with wlast=1; len=255: 256 beats with no counter wrap before wlast.
REQ-028 B: bready=1; on bvalid set err if bresp!=2'b00 or bid!=captured id, then move to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; earliest new start is accepted in IDLE.
REQ-030 Minimum latency from start to done, with ready/valid always asserted: len+5 cycles.
REQ-031 awvalid, wvalid and bready are driven from registers or state decode only, with no combinational path from any ready/valid input.

Reset
REQ-032 rst_wr=1 asynchronously forces IDLE and zeroes every output: valids, bready, wlast, busy, done, err, timeout, and all payload buses.
REQ-033 Reset asserted mid-burst abandons the burst; no further handshake is issued after release until a new start.

Configuration
REQ-034 Macro AIB_AXI_TG_TIMEOUT_EN defined: a 16-bit counter runs in B; reaching TIMEOUT_CYC without bvalid sets timeout=1 and err=1 and moves to DONE.
REQ-035 AIB_AXI_TG_TIMEOUT_EN undefined: B waits indefinitely, timeout is tied to 0, and the counter is not instantiated.

Verification
REQ-036 start, addr=0x1000, len=3, id=5, seed=0x10, all ready=1, bresp=0, bid=5 -> 4 beats with wdata words 0x10..0x13, wlast on beat 4, done at cycle 8, err=0.
REQ-037 Same burst with wready toggling 1/0 every cycle -> wdata/wlast stable across stalls, exactly 4 handshakes, done once.
REQ-038 len=0, bresp=2'b10 -> single beat with wlast=1, err=1 after done; next start clears err.
REQ-039 Second start pulsed during W; seed=0xFFFFFFFF, len=1 -> second start ignored; wdata words 0xFFFFFFFF then 0x00000000.
REQ-040 rst_wr asserted during W beat 2 of len=7 -> all outputs 0 immediately; after release, no valid asserts without start.
REQ-041 With AIB_AXI_TG_TIMEOUT_EN, TIMEOUT_CYC=16, bvalid held 0 -> timeout=1, err=1, done 16 cycles after entering B.

Source files
------------

// File: rtl/aib_axi_wr_traffic_gen.sv
// aib_axi_wr_traffic_gen: issues one AXI4 INCR write burst per start pulse and checks the B response.
// Optional B-channel watchdog enabled by defining AIB_AXI_TG_TIMEOUT_EN.
module aib_axi_wr_traffic_gen #(
    parameter int IDWIDTH     = 4,
    parameter int ADDRWIDTH   = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] cfg_addr,
    input  logic [7:0]           cfg_len,
    input  logic [IDWIDTH-1:0]   cfg_id,
    input  logic [31:0]          cfg_seed,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 timeout,
    output logic [IDWIDTH-1:0]   m_axi_awid,
    output logic [ADDRWIDTH-1:0] m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [IDWIDTH-1:0]   m_axi_wid,
    output logic [127:0]         m_axi_wdata,
    output logic [15:0]          m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [IDWIDTH-1:0]   m_axi_bid,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready
);
    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
    state_t state, state_nx;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [7:0]           len_q, beat;
    logic [IDWIDTH-1:0]   id_q;
    logic [31:0]          seed_q;
    logic                 err_q, to_hit, accept;

    assign accept = state == IDLE && start;

`ifdef AIB_AXI_TG_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_q;
    assign to_hit  = state == B && !m_axi_bvalid && to_cnt == 16'(TIMEOUT_CYC - 1);
    assign timeout = to_q;
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_cnt <= state == B ? to_cnt + 16'd1 : '0;
            if (accept) to_q <= 1'b0;
            else if (to_hit) to_q <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? AW : IDLE;
            AW:      state_nx = m_axi_awready ? W : AW;
            W:       state_nx = m_axi_wready && m_axi_wlast ? B : W;
            B:       state_nx = m_axi_bvalid || to_hit ? DONE : B;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
            seed_q <= '0;
            beat   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= cfg_addr;
                len_q  <= cfg_len;
                id_q   <= cfg_id;
                seed_q <= cfg_seed;
                beat   <= '0;
                err_q  <= 1'b0;
            end
            if (state == W && m_axi_wready) beat <= beat + 8'd1;
            if (state == B && m_axi_bvalid && (m_axi_bresp != 2'b00 || m_axi_bid != id_q)) err_q <= 1'b1;
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign err           = err_q;
    assign m_axi_awvalid = state == AW;
    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = state == AW ? 3'b100 : 3'b000;
    assign m_axi_awburst = state == AW ? 2'b01 : 2'b00;
    assign m_axi_wvalid  = state == W;
    assign m_axi_wid     = id_q;
    assign m_axi_wdata   = {4{seed_q + {24'd0, beat}}};
    assign m_axi_wstrb   = state == W ? 16'hFFFF : 16'h0000;
    assign m_axi_wlast   = state == W && beat == len_q;
    assign m_axi_bready  = state == B;
endmodule

// File: tb/tb_aib_axi_wr_traffic_gen.sv
// tb_aib_axi_wr_traffic_gen: directed bursts with a W-beat scoreboard and immediate-assertion checks.
module tb_aib_axi_wr_traffic_gen;
    logic         clk_wr = 0, rst_wr = 1, start = 0;
    logic [31:0]  cfg_addr = 0, cfg_seed = 0;
    logic [7:0]   cfg_len = 0;
    logic [3:0]   cfg_id = 0;
    logic         busy, done, err, timeout;
    logic [3:0]   awid, wid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready = 1;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready = 1;
    logic [3:0]   bid = 0;
    logic [1:0]   bresp = 0;
    logic         bvalid = 1, bready;
    logic         tog = 0;
    int           checks = 0, errors = 0, hs = 0;
    logic [32:0]  exp_q[$];
    logic         stalled = 0, prev_last = 0;
    logic [127:0] prev_data = 0;

    aib_axi_wr_traffic_gen #(.IDWIDTH(4), .ADDRWIDTH(32), .TIMEOUT_CYC(16)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .cfg_id(cfg_id), .cfg_seed(cfg_seed), .busy(busy), .done(done), .err(err), .timeout(timeout),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready));

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_wr); #1;
        if (tog) wready = ~wready;
    end

    // W monitor: scoreboard pop on each handshake, payload stability across stalls
    always @(negedge clk_wr) begin
        if (stalled && wvalid) begin
            chk("w_stable_data", wdata, prev_data);
            chk("w_stable_last", {127'd0, wlast}, {127'd0, prev_last});
        end
        stalled   = wvalid && !wready;
        prev_data = wdata;
        prev_last = wlast;
        if (wvalid && wready) begin
            hs++;
            if (exp_q.size() == 0) chk("w_unexpected_beat", 128'd1, 128'd0);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("w_data", wdata, {4{e[31:0]}});
                chk("w_last", {127'd0, wlast}, {127'd0, e[32]});
                chk("w_strb_id", {wstrb, wid}, {16'hFFFF, cfg_id});
            end
        end
    end

    task automatic burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                         input logic [31:0] s, input int lat, input int restart_at, input logic exp_err,
                         input logic exp_to);
        int c;
        @(posedge clk_wr); #1;
        cfg_addr = a; cfg_len = l; cfg_id = id; cfg_seed = s; start = 1; hs = 0;
        for (int i = 0; i <= int'(l); i++) exp_q.push_back({i == int'(l), s + 32'(i)});
        c = 1;
        forever begin
            @(negedge clk_wr);
            if (c == 2) begin
                chk("aw_valid", {127'd0, awvalid}, 128'd1);
                chk("aw_payload", {awid, awaddr, awlen, awsize, awburst}, {id, a, l, 3'b100, 2'b01});
                chk("err_cleared", {err, timeout}, 2'b00);
            end
            if (done || c >= 400) break;
            @(posedge clk_wr); #1;
            start = c == restart_at;
            if (start) cfg_seed = 32'hDEADBEEF;
            c++;
        end
        start = 0;
        chk("done_seen", {127'd0, done}, 128'd1);
        if (lat > 0) chk("latency", 128'(c), 128'(lat));
        chk("beats", 128'(hs), 128'(int'(l) + 1));
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        chk("err_flag", {err, timeout}, {exp_err, exp_to});
        @(negedge clk_wr);
        chk("done_pulse_one", {done, busy}, 2'b00);
        exp_q.delete();
    endtask

    initial begin
        #2;
        chk("reset_outputs", {awvalid, wvalid, bready, wlast, busy, done, err, timeout, awid, awaddr,
            awlen, awsize, awburst, wid, wdata, wstrb}, '0);
        #20 rst_wr = 0;
        bid = 5;
        burst(32'h1000, 8'd3, 4'd5, 32'h10, 8, 0, 0, 0);
        tog = 1;
        burst(32'h1000, 8'd3, 4'd5, 32'h10, -1, 0, 0, 0);
        tog = 0; wready = 1; bid = 2; bresp = 2'b10;
        burst(32'h2000, 8'd0, 4'd2, 32'hA5A5_0000, 5, 0, 1, 0);
        bresp = 2'b00; bid = 9;
        burst(32'h3000, 8'd1, 4'd9, 32'hFFFF_FFFF, 6, 3, 0, 0);
        bid = 3;
        burst(32'h4000, 8'd0, 4'd4, 32'h1, 5, 0, 1, 0);
        bid = 1;
        burst(32'h5000, 8'd255, 4'd1, 32'h7, 260, 0, 0, 0);
        // reset during the second beat of an 8-beat burst
        @(posedge clk_wr); #1;
        cfg_len = 7; cfg_id = 6; cfg_seed = 32'h100; start = 1; hs = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 32'h100 + 32'(i)});
        @(posedge clk_wr); #1 start = 0;
        for (int i = 0; i < 50 && hs < 1; i++) @(negedge clk_wr);
        chk("reached_beat2", 128'(hs), 128'd1);
        chk("beat2_valid", {127'd0, wvalid}, 128'd1);
        #1 rst_wr = 1;
        #1 chk("async_reset_outputs", {awvalid, wvalid, bready, wlast, busy, done, err, timeout, awid,
            awaddr, awlen, awsize, awburst, wid, wdata, wstrb}, '0);
        exp_q.delete();
        @(posedge clk_wr); #1 rst_wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_wr);
            chk("idle_after_reset", {awvalid, wvalid, bready, busy}, 4'b0000);
        end
`ifdef AIB_AXI_TG_TIMEOUT_EN
        bvalid = 0; bid = 0;
        burst(32'h6000, 8'd0, 4'd0, 32'h0, 20, 0, 1, 1);
        bvalid = 1;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
